// File: rtl/pattern_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
// Mode encoding matches the legacy 2-bit mode_req/mode_active ports.
package pattern_pkg;

   typedef enum logic [1:0] {
      MODE_CHECKER  = 2'd0,
      MODE_FRACTAL  = 2'd1,
      MODE_NOISE    = 2'd2,
      MODE_GRADIENT = 2'd3
   } mode_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One step of a right-shifting Galois LFSR.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR noise source; advances only when en is high.
module lfsr16
   import pattern_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= LFSR_SEED;
      end else if (en) begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/pattern_gen.sv
// Runtime-switchable VGA test-pattern generator: checker, fractal, noise and
// gradient, with mode changes taken through a handshake and applied at (0,0).
module pattern_gen
   import pattern_pkg::*;
#(
   parameter int unsigned COLOR_W     = 4,
   parameter int unsigned ACTIVE_W    = 640,
   parameter int unsigned ACTIVE_H    = 480,
   parameter int unsigned CELL_LOG2   = 2,
   parameter int unsigned FRAC_LEVELS = 4,
   parameter int unsigned PIPE        = 1
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9:0]         position_x,
   input  logic [8:0]         position_y,
   input  logic [9:0]         position_x_NEXT,
   input  logic [8:0]         position_y_NEXT,
   input  logic [31:0]        frame,
   input  logic [1:0]         mode_req,
   input  logic               mode_req_valid,
   output logic               mode_req_ready,
   output logic [1:0]         mode_active,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b
);

   localparam int unsigned FRAC_E = 1 << (2 * FRAC_LEVELS);
   localparam int unsigned FW     = 2 * FRAC_LEVELS;
   localparam int unsigned OX     = (ACTIVE_W > FRAC_E) ? (ACTIVE_W - FRAC_E) / 2 : 0;
   localparam int unsigned OY     = (FRAC_E > ACTIVE_H) ? (FRAC_E - ACTIVE_H) / 2 : 0;
   localparam int unsigned CW3    = 3 * COLOR_W;

   mode_e            mode_q;
   mode_e            pend_mode;
   mode_e            eff_mode;
   logic             pend_valid;
   logic             active;
   logic             boundary;
   logic [15:0]      lfsr_q;
   logic             chk_c;
   logic [FW-1:0]    sx;
   logic [FW-1:0]    sy;
   logic             frac_in;
   logic             frac_c;
   logic [CW3-1:0]   rgb_d;
   logic [CW3-1:0]   pipe_q [PIPE];

   assign active   = (32'(position_x_NEXT) < ACTIVE_W) && (32'(position_y_NEXT) < ACTIVE_H);
   assign boundary = (position_x_NEXT == '0) && (position_y_NEXT == '0);

   // The boundary pixel itself already uses the pending mode.
   assign eff_mode       = (boundary && pend_valid) ? pend_mode : mode_q;
   assign mode_active    = mode_q;
   assign mode_req_ready = ~pend_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= MODE_CHECKER;
         pend_mode  <= MODE_CHECKER;
         pend_valid <= 1'b0;
      end else if (boundary && pend_valid) begin
         mode_q     <= pend_mode;
         pend_valid <= 1'b0;
      end else if (mode_req_valid && !pend_valid) begin
         pend_mode  <= mode_e'(mode_req);
         pend_valid <= 1'b1;
      end
   end

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (active),
      .q     (lfsr_q)
   );

   assign chk_c = position_x_NEXT[CELL_LOG2] ^ position_y_NEXT[CELL_LOG2];

   assign sx      = FW'(position_x_NEXT - 10'(OX));
   assign sy      = FW'({1'b0, position_y_NEXT} + 10'(OY));
   assign frac_in = (32'(position_x_NEXT) >= OX) && (32'(position_x_NEXT) < OX + FRAC_E);

   always_comb begin
      frac_c = 1'b1;
      for (int unsigned k = 0; k < FRAC_LEVELS; k++) begin
         frac_c = frac_c & ((sx[2*k+1] ^ sx[2*k]) | (sy[2*k+1] ^ sy[2*k]));
      end
   end

   always_comb begin
      rgb_d = '0;
      if (active) begin
         case (eff_mode)
            MODE_CHECKER:  rgb_d = {{COLOR_W{chk_c & frame[1]}},
                                   {COLOR_W{chk_c & frame[0]}},
                                   {COLOR_W{chk_c & frame[2]}}};
            MODE_FRACTAL:  if (frac_in) rgb_d = {CW3{frac_c}};
            MODE_NOISE:    rgb_d = {lfsr_q[0 +: COLOR_W], lfsr_q[4 +: COLOR_W],
                                    lfsr_q[8 +: COLOR_W]};
            MODE_GRADIENT: rgb_d = {position_x_NEXT[9 -: COLOR_W],
                                    position_y_NEXT[8 -: COLOR_W], frame[7 -: COLOR_W]};
            default:       rgb_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < PIPE; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= rgb_d;
         for (int unsigned i = 1; i < PIPE; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign {r, g, b} = pipe_q[PIPE-1];

   logic unused_ok;
   assign unused_ok = ^{position_x, position_y, frame[31:8], lfsr_q[15:12]};

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: two instances (PIPE=1 and PIPE=3) share
// stimulus; each has a monitor popping expected colours at its own latency.
module tb_pattern_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  px = '0;
   logic [8:0]  py = '0;
   logic [9:0]  pxn = '0;
   logic [8:0]  pyn = '0;
   logic [31:0] frame = '0;
   logic [1:0]  mode_req = '0;
   logic        mode_req_valid = 1'b0;

   logic        ready1, ready3;
   logic [1:0]  mact1, mact3;
   logic [3:0]  r1, g1, b1, r3, g3, b3;

   typedef struct packed {
      logic        chk;
      logic [9:0]  x;
      logic [8:0]  y;
      logic [11:0] rgb;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pattern_gen dut (
      .clk (clk), .rst_n (rst_n),
      .position_x (px), .position_y (py),
      .position_x_NEXT (pxn), .position_y_NEXT (pyn),
      .frame (frame), .mode_req (mode_req), .mode_req_valid (mode_req_valid),
      .mode_req_ready (ready1), .mode_active (mact1),
      .r (r1), .g (g1), .b (b1)
   );

   pattern_gen #(.PIPE(3)) dut3 (
      .clk (clk), .rst_n (rst_n),
      .position_x (px), .position_y (py),
      .position_x_NEXT (pxn), .position_y_NEXT (pyn),
      .frame (frame), .mode_req (mode_req), .mode_req_valid (mode_req_valid),
      .mode_req_ready (ready3), .mode_active (mact3),
      .r (r3), .g (g3), .b (b3)
   );

   // Presents one coordinate for the next rising edge and queues its expected colour.
   task automatic drive(input int x, input int y, input logic [31:0] fr,
                        input logic chk, input logic [11:0] rgb);
      exp_t e;
      pxn   = 10'(x);
      pyn   = 9'(y);
      frame = fr;
      e.chk = chk;
      e.x   = 10'(x);
      e.y   = 9'(y);
      e.rgb = rgb;
      q1.push_back(e);
      q3.push_back(e);
      @(negedge clk);
   endtask

   task automatic ctl(input string name, input logic er, input logic [1:0] em);
      checks++;
      if (ready1 !== er || mact1 !== em) begin
         errors++;
         $display("FAIL %s pipe1: ready=%0b mode=%0d, expected ready=%0b mode=%0d",
                  name, ready1, mact1, er, em);
      end
      checks++;
      if (ready3 !== er || mact3 !== em) begin
         errors++;
         $display("FAIL %s pipe3: ready=%0b mode=%0d, expected ready=%0b mode=%0d",
                  name, ready3, mact3, er, em);
      end
   endtask

   task automatic chk_reset(input string name);
      checks++;
      if ({r1, g1, b1} !== 12'h000 || {r3, g3, b3} !== 12'h000) begin
         errors++;
         $display("FAIL %s rgb: pipe1=%h pipe3=%h, expected 000", name, {r1, g1, b1}, {r3, g3, b3});
      end
      checks++;
      if (dut.u_lfsr.q !== 16'hACE1 || dut3.u_lfsr.q !== 16'hACE1) begin
         errors++;
         $display("FAIL %s lfsr: pipe1=%h pipe3=%h, expected ace1", name, dut.u_lfsr.q, dut3.u_lfsr.q);
      end
   endtask

   task automatic monitor(input int which, input int depth);
      exp_t        infl[$];
      exp_t        e;
      logic [11:0] act;
      forever begin
         @(posedge clk);
         if (which == 0 && q1.size() > 0) infl.push_back(q1.pop_front());
         else if (which == 1 && q3.size() > 0) infl.push_back(q3.pop_front());
         else begin
            errors++;
            $display("FAIL scoreboard_underflow pipe%0d: no expected entry at %0t", depth, $time);
         end
         if (infl.size() >= depth) begin
            #1;
            e   = infl.pop_front();
            act = (which == 0) ? {r1, g1, b1} : {r3, g3, b3};
            if (e.chk) begin
               checks++;
               if (act !== e.rgb) begin
                  errors++;
                  $display("FAIL pixel pipe%0d (%0d,%0d): rgb=%h expected %h",
                           depth, e.x, e.y, act, e.rgb);
               end
            end
         end
      end
   endtask

   initial begin
      fork
         monitor(0, 1);
         monitor(1, 3);
      join_none
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(700, 0, 0, 0, 0);
      drive(700, 0, 0, 0, 0);
      chk_reset("power_on_reset");
      ctl("power_on_ctl", 1'b1, 2'd0);
      rst_n = 1'b1;

      // Checker, CELL_LOG2=2: cell bit is coordinate bit 2.
      drive(4,   0,   3, 1, 12'hFF0);
      drive(4,   4,   3, 1, 12'h000);
      drive(8,   4,   3, 1, 12'hFF0);
      drive(4,   0,   6, 1, 12'hF0F);
      drive(700, 0,   3, 1, 12'h000);
      drive(4,   480, 3, 1, 12'h000);

      // Fractal request mid-frame; window is x in [192,448).
      mode_req = 2'd1;
      mode_req_valid = 1'b1;
      drive(100, 200, 3, 1, 12'hFF0);
      ctl("fractal_req_accepted", 1'b0, 2'd0);
      mode_req_valid = 1'b0;
      mode_req = 2'd0;
      drive(101, 200, 3, 1, 12'hFF0);
      ctl("fractal_waits_boundary", 1'b0, 2'd0);
      drive(0,   0,   3, 1, 12'h000);
      ctl("fractal_applied", 1'b1, 2'd1);
      drive(277, 0,   0, 1, 12'hFFF);
      drive(276, 0,   0, 1, 12'h000);
      drive(191, 0,   0, 1, 12'h000);
      drive(192, 85,  0, 1, 12'hFFF);
      drive(447, 0,   0, 1, 12'h000);
      drive(448, 85,  0, 1, 12'h000);
      drive(193, 86,  0, 1, 12'hFFF);
      drive(277, 480, 0, 1, 12'h000);

      // Asynchronous reset while outputs are white mid-frame.
      drive(277, 0, 0, 1, 12'hFFF);
      drive(277, 0, 0, 0, 12'h000);
      drive(277, 0, 0, 0, 12'h000);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("async_reset");
      ctl("async_reset_ctl", 1'b1, 2'd0);
      drive(700, 0, 0, 0, 0);
      drive(700, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Noise from the seed; held request while busy is taken one cycle after apply.
      mode_req = 2'd2;
      mode_req_valid = 1'b1;
      drive(700, 0, 0, 1, 12'h000);
      ctl("noise_req_accepted", 1'b0, 2'd0);
      mode_req = 2'd3;
      drive(701, 0, 0, 1, 12'h000);
      ctl("busy_ignores_valid", 1'b0, 2'd0);
      drive(0,   0, 0, 1, 12'h1EC);
      ctl("noise_applied", 1'b1, 2'd2);
      drive(1,   0, 0, 1, 12'h072);
      ctl("held_req_accepted", 1'b0, 2'd2);
      mode_req_valid = 1'b0;
      mode_req = 2'd0;
      drive(700, 0, 0, 1, 12'h000);
      drive(2,   0, 0, 1, 12'h831);
      drive(3,   0, 0, 1, 12'hC98);

      // Gradient; a request accepted on a boundary waits for the next one.
      drive(0, 0, 32'hA0, 1, 12'h00A);
      ctl("gradient_applied", 1'b1, 2'd3);
      mode_req = 2'd1;
      mode_req_valid = 1'b1;
      drive(0, 0, 32'hA0, 1, 12'h00A);
      ctl("accept_on_boundary", 1'b0, 2'd3);
      mode_req_valid = 1'b0;
      mode_req = 2'd0;
      drive(639, 479, 32'hA0, 1, 12'h9EA);
      drive(640, 0,   32'hA0, 1, 12'h000);
      drive(639, 0,   32'hA0, 1, 12'h90A);
      drive(0,   480, 32'hA0, 1, 12'h000);
      drive(0,   0,   0,      1, 12'h000);
      ctl("deferred_applied", 1'b1, 2'd1);

      for (int i = 0; i < 4; i++) drive(700, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
